maze_cursor_ctrl: RTL and testbench
===================================

Name: maze_cursor_ctrl

Overview:
- Sequencer for the maze wire-cutting game. Moves the player cursor over the 18x11 maze grid from debounced buttons at a 10 Hz tick.
- Enforces the checkpoint order (colours 1..5), hands off to the wire cutter at each checkpoint, and handles wall collisions with a respawn.
- Drives the count and curr_colour inputs of the red-square renderer.

Parameters:
- COLS, 18, grid columns.
- ROWS, 11, grid rows; cells 0..COLS*ROWS-1, max 197.
- START_CELL, 181, spawn cell and initial respawn point.
- DEAD_TICKS, 10, ticks the collision marker (count=255) is held.
- MAX_LIVES, 3, starting lives (used only with LIVES_EN).

Ports:
- CLK  in  1  6.25 MHz system clock
- RESET_N  in  1  asynchronous active-low reset
- tick  in  1  one-CLK pulse at 10 Hz; the only move/timer enable
- btn_up, btn_down, btn_left, btn_right  in  1 each  debounced levels
- mazestate  in  198  1 = open cell, 0 = wall
- cut_ack  in  1  cutter done, one-CLK pulse
- cut_ok  in  1  qualifies cut_ack: 1 = correct wire cut
- count  out  8  cursor cell index, or 255 = collision marker
- curr_colour  out  3  next required checkpoint colour, 1..5
- cut_req  out  1  level; held high until cut_ack
- wire_to_cut  out  3  colour being cut; 3'b111 when idle
- game_won  out  1  sticky once all 5 are cut
- game_over  out  1  sticky; driven only with LIVES_EN, else tied 0
- lives_left  out  2  driven only with LIVES_EN, else tied MAX_LIVES

Behaviour:
- Reset values: count=START_CELL, row/col decoded from START_CELL, curr_colour=1, respawn=START_CELL, cut_req=0, wire_to_cut=3'b111, game_won=0, game_over=0, lives_left=MAX_LIVES, state=NAV, dead timer=0.
- Reset asserted mid-operation aborts everything, including a pending cut_req.
- Position is held as row (4b) and col (5b) registers; count=row*COLS+col, registered. No divider.
- Checkpoint table: colour1=31, colour2=113, colour3=178, colour4=37, colour5=139.
- States: NAV, CUT_WAIT, DEAD, WON, OVER.
- NAV, on a tick with a button held: direction priority is up > down > left > right; one cell per tick.
  - Target off-grid (row 0 up, row ROWS-1 down, col 0 left, col COLS-1 right): no move, no wrap.
  - mazestate[target]=0: count<=255, timer<=0, go to DEAD.
  - Otherwise: move. If target equals the checkpoint cell for curr_colour, then cut_req<=1, wire_to_cut<=curr_colour, go to CUT_WAIT.
  - Checkpoint cells of other colours are plain open cells.
- NAV tick with no button: no change.
- CUT_WAIT: ticks and buttons ignored.
  - cut_ack & cut_ok: respawn<=current cell, cut_req<=0, wire_to_cut<=111. If curr_colour==5, game_won<=1 and go to WON; else curr_colour++ and go to NAV.
  - cut_ack & !cut_ok: cut_req<=0, count<=255, go to DEAD (wrong-wire penalty).
  - cut_ack in any other state is ignored.
- DEAD: timer increments per tick. When the timer reaches DEAD_TICKS-1 on a tick: count/row/col<=respawn, go to NAV. Latency is exactly DEAD_TICKS ticks from collision to respawn.
- WON and OVER are terminal until reset; the cursor freezes.
- Latency: count updates on the CLK edge following the tick edge.

Optional Feature:
- LIVES_EN defined:
  - Each DEAD entry decrements lives_left.
  - Entering DEAD with lives_left==1 sets lives_left<=0, holds count=255, sets game_over=1 and goes to OVER; no respawn.
- LIVES_EN undefined:
  - Infinite respawns; the OVER state is unreachable.
  - lives_left tied to MAX_LIVES, game_over tied to 0.

Decomposition:
- Package maze_pkg holds: COLS, ROWS, COLLIDE_CELL=255, WIRE_NONE=3'b111, state enum, and the checkpoint cell constant array indexed by colour.
- Sub-module maze_step (combinational): takes row, col and direction; returns target row/col, target index and an off-grid flag. Keeps the FSM free of grid arithmetic.

Test Plan:
- Reset, then tick with no buttons -> count=181, curr_colour=1, wire_to_cut=111, cut_req=0.
- Open path, hold btn_right 3 ticks from 181 -> count 182, 183, 184, one per tick. Hold btn_left and btn_up together -> up wins.
- Wall at 182, press right -> count=255 for exactly 10 ticks, then count=181, state NAV; with LIVES_EN, lives_left 3->2.
- Walk to 31 with curr_colour=1 -> cut_req=1, wire_to_cut=1, buttons ignored. cut_ack+cut_ok -> curr_colour=2, cut_req=0. A later collision respawns at 31.
- At 31, cut_ack with cut_ok=0 -> count=255, then respawn at 181; curr_colour stays 1. Entering 113 while curr_colour=1 -> no cut_req.
- Force all 5 checkpoints in order -> game_won=1 after the fifth ack, cursor frozen. LIVES_EN with 3 collisions -> game_over=1, count stays 255.

Source files
------------

// File: rtl/maze_cursor_ctrl_pkg.sv
// Shared constants and types for the maze cursor sequencer (package maze_pkg).
package maze_pkg;

    localparam int COLS  = 18;
    localparam int ROWS  = 11;
    localparam int CELLS = COLS * ROWS;

    localparam logic [7:0] COLLIDE_CELL = 8'd255;
    localparam logic [2:0] WIRE_NONE    = 3'b111;
    localparam logic [2:0] LAST_COLOUR  = 3'd5;

    typedef enum logic [2:0] {
        S_NAV,
        S_CUT_WAIT,
        S_DEAD,
        S_WON,
        S_OVER
    } state_t;

    typedef enum logic [1:0] {
        DIR_UP,
        DIR_DOWN,
        DIR_LEFT,
        DIR_RIGHT
    } dir_t;

    // Indexed by colour; entries 0, 6 and 7 are never valid checkpoint colours.
    localparam logic [7:0] CHECKPOINT [8] = '{8'd0, 8'd31, 8'd113, 8'd178,
                                              8'd37, 8'd139, 8'd0, 8'd0};

    function automatic logic [7:0] checkpoint_cell(input logic [2:0] colour);
        return CHECKPOINT[colour];
    endfunction

endpackage

// File: rtl/maze_cursor_ctrl_if.sv
// Game-side signal bundle of the maze cursor sequencer: buttons, tick, maze map,
// wire-cutter handshake and renderer/status outputs.
interface maze_cursor_ctrl_if #(
    parameter int CELLS = maze_pkg::CELLS
);
    logic             tick;
    logic             btn_up;
    logic             btn_down;
    logic             btn_left;
    logic             btn_right;
    logic [CELLS-1:0] mazestate;
    logic             cut_ack;
    logic             cut_ok;
    logic [7:0]       count;
    logic [2:0]       curr_colour;
    logic             cut_req;
    logic [2:0]       wire_to_cut;
    logic             game_won;
    logic             game_over;
    logic [1:0]       lives_left;

    modport master (
        output tick, btn_up, btn_down, btn_left, btn_right, mazestate, cut_ack, cut_ok,
        input  count, curr_colour, cut_req, wire_to_cut, game_won, game_over, lives_left
    );

    modport slave (
        input  tick, btn_up, btn_down, btn_left, btn_right, mazestate, cut_ack, cut_ok,
        output count, curr_colour, cut_req, wire_to_cut, game_won, game_over, lives_left
    );

endinterface

// File: rtl/maze_cursor_ctrl_step.sv
// Combinational one-cell step on the maze grid: target row/col/index and an
// off-grid flag. The target stays on the current cell when off-grid.
module maze_step #(
    parameter int COLS = maze_pkg::COLS,
    parameter int ROWS = maze_pkg::ROWS
) (
    input  logic           [3:0] row,
    input  logic           [4:0] col,
    input  maze_pkg::dir_t       dir,
    output logic           [3:0] target_row,
    output logic           [4:0] target_col,
    output logic           [7:0] target_cell,
    output logic                 off_grid
);

    localparam logic [3:0] LAST_ROW = 4'(ROWS - 1);
    localparam logic [4:0] LAST_COL = 5'(COLS - 1);
    localparam logic [7:0] COLS_W   = 8'(COLS);

    always_comb begin
        target_row = row;
        target_col = col;
        off_grid   = 1'b0;
        case (dir)
            maze_pkg::DIR_UP: begin
                if (row == 4'd0) off_grid = 1'b1;
                else             target_row = row - 4'd1;
            end
            maze_pkg::DIR_DOWN: begin
                if (row == LAST_ROW) off_grid = 1'b1;
                else                 target_row = row + 4'd1;
            end
            maze_pkg::DIR_LEFT: begin
                if (col == 5'd0) off_grid = 1'b1;
                else             target_col = col - 5'd1;
            end
            default: begin
                if (col == LAST_COL) off_grid = 1'b1;
                else                 target_col = col + 5'd1;
            end
        endcase
    end

    // Constant multiply only; the largest index (197) fits in 8 bits.
    assign target_cell = 8'(target_row) * COLS_W + 8'(target_col);

endmodule

// File: rtl/maze_cursor_ctrl.sv
// Maze wire-cutting game sequencer: cursor movement, checkpoint order, cutter
// hand-off and collision respawn. Optional lives/game-over with `define LIVES_EN.
module maze_cursor_ctrl #(
    parameter int COLS       = 18,
    parameter int ROWS       = 11,
    parameter int START_CELL = 181,
    parameter int DEAD_TICKS = 10,
    parameter int MAX_LIVES  = 3
) (
    input  logic                CLK,
    input  logic                RESET_N,
    maze_cursor_ctrl_if.slave   bus
);

    import maze_pkg::*;

    localparam int         TW         = $clog2(DEAD_TICKS + 1);
    localparam logic [3:0] START_ROW  = 4'(START_CELL / COLS);
    localparam logic [4:0] START_COL  = 5'(START_CELL % COLS);
    localparam logic [7:0] START_IDX  = 8'(START_CELL);
    localparam logic [TW-1:0] TIMER_LAST = TW'(DEAD_TICKS - 1);

    state_t        state;
    logic [3:0]    row;
    logic [4:0]    col;
    logic [7:0]    count_r;
    logic [2:0]    colour;
    logic [3:0]    respawn_row;
    logic [4:0]    respawn_col;
    logic [7:0]    respawn_cell;
    logic          cut_req_r;
    logic [2:0]    wire_r;
    logic          won_r;
    logic [TW-1:0] dead_timer;

    dir_t       dir;
    logic       btn_any;
    logic [3:0] tgt_row;
    logic [4:0] tgt_col;
    logic [7:0] tgt_cell;
    logic       off_grid;
    logic       tgt_open;
    logic       nav_move;
    state_t     death_state;

    always_comb begin
        btn_any = bus.btn_up | bus.btn_down | bus.btn_left | bus.btn_right;
        dir     = DIR_RIGHT;
        if (bus.btn_up)        dir = DIR_UP;
        else if (bus.btn_down) dir = DIR_DOWN;
        else if (bus.btn_left) dir = DIR_LEFT;
    end

    maze_step #(
        .COLS (COLS),
        .ROWS (ROWS)
    ) u_step (
        .row         (row),
        .col         (col),
        .dir         (dir),
        .target_row  (tgt_row),
        .target_col  (tgt_col),
        .target_cell (tgt_cell),
        .off_grid    (off_grid)
    );

    assign tgt_open = bus.mazestate[tgt_cell];
    assign nav_move = (state == S_NAV) && bus.tick && btn_any && !off_grid;

`ifdef LIVES_EN
    logic [1:0] lives_r;
    logic       over_r;
    logic       collide;

    // Losing the last life skips the respawn timer entirely.
    assign death_state = (lives_r == 2'd1) ? S_OVER : S_DEAD;
    assign collide     = (nav_move && !tgt_open) ||
                         ((state == S_CUT_WAIT) && bus.cut_ack && !bus.cut_ok);

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            lives_r <= 2'(MAX_LIVES);
            over_r  <= 1'b0;
        end else if (collide) begin
            lives_r <= lives_r - 2'd1;
            if (lives_r == 2'd1) over_r <= 1'b1;
        end
    end

    assign bus.lives_left = lives_r;
    assign bus.game_over  = over_r;
`else
    assign death_state    = S_DEAD;
    assign bus.lives_left = 2'(MAX_LIVES);
    assign bus.game_over  = 1'b0;
`endif

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state        <= S_NAV;
            row          <= START_ROW;
            col          <= START_COL;
            count_r      <= START_IDX;
            colour       <= 3'd1;
            respawn_row  <= START_ROW;
            respawn_col  <= START_COL;
            respawn_cell <= START_IDX;
            cut_req_r    <= 1'b0;
            wire_r       <= WIRE_NONE;
            won_r        <= 1'b0;
            dead_timer   <= '0;
        end else begin
            case (state)
                S_NAV: begin
                    if (nav_move) begin
                        if (!tgt_open) begin
                            count_r    <= COLLIDE_CELL;
                            dead_timer <= '0;
                            state      <= death_state;
                        end else begin
                            row     <= tgt_row;
                            col     <= tgt_col;
                            count_r <= tgt_cell;
                            // Only the checkpoint of the currently required colour triggers a cut.
                            if (tgt_cell == checkpoint_cell(colour)) begin
                                cut_req_r <= 1'b1;
                                wire_r    <= colour;
                                state     <= S_CUT_WAIT;
                            end
                        end
                    end
                end
                S_CUT_WAIT: begin
                    if (bus.cut_ack) begin
                        cut_req_r <= 1'b0;
                        wire_r    <= WIRE_NONE;
                        if (bus.cut_ok) begin
                            respawn_row  <= row;
                            respawn_col  <= col;
                            respawn_cell <= count_r;
                            if (colour == LAST_COLOUR) begin
                                won_r <= 1'b1;
                                state <= S_WON;
                            end else begin
                                colour <= colour + 3'd1;
                                state  <= S_NAV;
                            end
                        end else begin
                            count_r    <= COLLIDE_CELL;
                            dead_timer <= '0;
                            state      <= death_state;
                        end
                    end
                end
                S_DEAD: begin
                    if (bus.tick) begin
                        if (dead_timer == TIMER_LAST) begin
                            row     <= respawn_row;
                            col     <= respawn_col;
                            count_r <= respawn_cell;
                            state   <= S_NAV;
                        end else begin
                            dead_timer <= dead_timer + 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.count       = count_r;
    assign bus.curr_colour = colour;
    assign bus.cut_req     = cut_req_r;
    assign bus.wire_to_cut = wire_r;
    assign bus.game_won    = won_r;

endmodule

// File: tb/tb_maze_cursor_ctrl.sv
// Bench for maze_cursor_ctrl: directed game scenarios plus random button/maze
// traffic, all checked against a cell-index reference model.
module tb_maze_cursor_ctrl;

    localparam int COLS       = 18;
    localparam int ROWS       = 11;
    localparam int CELLS      = COLS * ROWS;
    localparam int START      = 181;
    localparam int DEAD_TICKS = 10;
    localparam int MAX_LIVES  = 3;

    logic clk = 1'b0;
    logic rst_n;
    logic [CELLS-1:0] maze;

    int n_assert;
    int n_fail;

    int m_cell, m_show, m_colour, m_respawn, m_dead_left, m_lives;
    bit m_cut, m_won, m_over;
    int cp [6] = '{0, 31, 113, 178, 37, 139};

    always #5 clk = ~clk;

    maze_cursor_ctrl_if bus ();
    assign bus.mazestate = maze;

    maze_cursor_ctrl #(
        .COLS       (COLS),
        .ROWS       (ROWS),
        .START_CELL (START),
        .DEAD_TICKS (DEAD_TICKS),
        .MAX_LIVES  (MAX_LIVES)
    ) dut (
        .CLK     (clk),
        .RESET_N (rst_n),
        .bus     (bus)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic void model_reset();
        m_cell = START; m_show = START; m_colour = 1; m_respawn = START;
        m_dead_left = 0; m_lives = MAX_LIVES;
        m_cut = 0; m_won = 0; m_over = 0;
    endfunction

    function automatic void model_collide();
        m_show = 255;
        m_dead_left = DEAD_TICKS;
`ifdef LIVES_EN
        m_lives--;
        if (m_lives == 0) m_over = 1;
`endif
    endfunction

    function automatic void model_tick(input bit u, input bit d, input bit l, input bit r);
        int row, col, tgt;
        if (m_won || m_over || m_cut) return;
        if (m_dead_left > 0) begin
            m_dead_left--;
            if (m_dead_left == 0) begin
                m_cell = m_respawn;
                m_show = m_cell;
            end
            return;
        end
        row = m_cell / COLS;
        col = m_cell % COLS;
        tgt = -1;
        if (u)      begin if (row > 0)        tgt = m_cell - COLS; end
        else if (d) begin if (row < ROWS - 1) tgt = m_cell + COLS; end
        else if (l) begin if (col > 0)        tgt = m_cell - 1;    end
        else if (r) begin if (col < COLS - 1) tgt = m_cell + 1;    end
        if (tgt < 0) return;
        if (!maze[tgt]) begin
            model_collide();
            return;
        end
        m_cell = tgt;
        m_show = tgt;
        if (tgt == cp[m_colour]) m_cut = 1;
    endfunction

    function automatic void model_ack(input bit ok);
        if (!m_cut) return;
        m_cut = 0;
        if (ok) begin
            m_respawn = m_cell;
            if (m_colour == 5) m_won = 1;
            else m_colour++;
        end else begin
            model_collide();
        end
    endfunction

    task automatic check_all();
        check("count", bus.count, m_show);
        check("curr_colour", bus.curr_colour, m_colour);
        check("cut_req", bus.cut_req, m_cut);
        check("wire_to_cut", bus.wire_to_cut, m_cut ? m_colour : 7);
        check("game_won", bus.game_won, m_won);
        check("game_over", bus.game_over, m_over);
        check("lives_left", bus.lives_left, m_lives);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        bus.tick = 0; bus.btn_up = 0; bus.btn_down = 0; bus.btn_left = 0; bus.btn_right = 0;
        bus.cut_ack = 0; bus.cut_ok = 0;
        #2;
        model_reset();
        check_all();
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic do_tick(input bit u, input bit d, input bit l, input bit r);
        @(negedge clk);
        bus.btn_up = u; bus.btn_down = d; bus.btn_left = l; bus.btn_right = r;
        bus.tick = 1'b1;
        @(negedge clk);
        bus.tick = 1'b0;
        model_tick(u, d, l, r);
        check_all();
    endtask

    task automatic do_ack(input bit ok);
        @(negedge clk);
        bus.cut_ack = 1'b1;
        bus.cut_ok  = ok;
        @(negedge clk);
        bus.cut_ack = 1'b0;
        model_ack(ok);
        check_all();
    endtask

    task automatic goto_cell(input int target);
        for (int i = 0; i < 60; i++) begin
            int row, col, tr, tc;
            if (m_cell == target || m_cut || m_dead_left > 0) break;
            row = m_cell / COLS; col = m_cell % COLS;
            tr = target / COLS;  tc = target % COLS;
            do_tick(tr < row, tr > row, (tr == row) && (tc < col), (tr == row) && (tc > col));
        end
    endtask

    initial begin
        int dead;
        logic [3:0] b;
        n_assert = 0;
        n_fail   = 0;
        rst_n    = 1'b1;
        maze     = '1;

        do_reset();
        check("reset_count", bus.count, 181);
        do_tick(0, 0, 0, 0);
        check("idle_count", bus.count, 181);
        check("idle_colour", bus.curr_colour, 1);
        check("idle_wire", bus.wire_to_cut, 3'b111);
        check("idle_cut_req", bus.cut_req, 0);

        do_tick(0, 0, 0, 1); check("right1", bus.count, 182);
        do_tick(0, 0, 0, 1); check("right2", bus.count, 183);
        do_tick(0, 0, 0, 1); check("right3", bus.count, 184);
        do_tick(1, 0, 1, 0); check("up_beats_left", bus.count, 166);

        // Wall collision and respawn latency
        maze = '1; maze[182] = 1'b0;
        do_reset();
        do_tick(0, 0, 0, 1);
        check("wall_marker", bus.count, 255);
        dead = 1;
        for (int i = 0; i < 20; i++) begin
            do_tick(0, 0, 0, 0);
            if (bus.count != 8'd255) break;
            dead++;
        end
        check("dead_ticks", dead, DEAD_TICKS);
        check("respawn_start", bus.count, 181);
`ifdef LIVES_EN
        check("lives_after_wall", bus.lives_left, 2);
`endif

        // Checkpoint handling
        maze = '1;
        do_reset();
        goto_cell(109);
        goto_cell(113);
        check("cp2_out_of_order", bus.cut_req, 0);
        goto_cell(31);
        check("cp1_req", bus.cut_req, 1);
        check("cp1_wire", bus.wire_to_cut, 1);
        do_tick(0, 1, 0, 0);
        check("cut_wait_frozen", bus.count, 31);
        do_ack(0);
        check("wrong_wire_marker", bus.count, 255);
        repeat (DEAD_TICKS) do_tick(0, 0, 0, 0);
        check("wrong_wire_respawn", bus.count, 181);
        check("wrong_wire_colour", bus.curr_colour, 1);
        goto_cell(31);
        do_ack(1);
        check("cp1_done_colour", bus.curr_colour, 2);
        check("cp1_done_req", bus.cut_req, 0);
        maze[13] = 1'b0;
        do_tick(1, 0, 0, 0);
        check("cp_wall_marker", bus.count, 255);
        repeat (DEAD_TICKS) do_tick(0, 0, 0, 0);
        check("respawn_cp1", bus.count, 31);
        maze = '1;
        for (int c = 2; c <= 5; c++) begin
            goto_cell(cp[c]);
            check("cp_req", bus.cut_req, 1);
            check("cp_wire", bus.wire_to_cut, c);
            do_ack(1);
        end
        check("won", bus.game_won, 1);
        do_tick(0, 1, 0, 0);
        check("won_frozen", bus.count, 139);
        do_ack(1);
        check("won_sticky", bus.game_won, 1);

        // Random traffic over random mazes
        for (int blk = 0; blk < 4; blk++) begin
            for (int i = 0; i < CELLS; i++) maze[i] = ($urandom_range(0, 99) < 85);
            maze[START] = 1'b1;
            do_reset();
            for (int s = 0; s < 200; s++) begin
                if ($urandom_range(0, 7) == 0) begin
                    do_ack(1'($urandom_range(0, 1)));
                end else begin
                    b = 4'($urandom_range(0, 15));
                    do_tick(b[0], b[1], b[2], b[3]);
                end
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
